// File: rtl/apb4_master.sv
`default_nettype none
// ============================================================================
// Module   : apb4_master
// Purpose  : APB4 requester. Turns a valid/ready command stream into single,
//            non-pipelined APB4 SETUP/ACCESS transfers and returns the result
//            on a valid/ready response channel. One transfer in flight at a
//            time; every output is driven straight from a flop.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            cmd_*             - command channel (valid/ready, write, addr,
//                                wdata, wstrb, prot)
//            rsp_*             - response channel (valid/ready, rdata, err)
//            paddr..pprot      - APB4 requester outputs
//            prdata, pready,
//            pslverr           - APB4 completer returns
// Options  : APB4_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees
//            pready low for TIMEOUT_CYCLES cycles is aborted with rsp_err=1.
//            DATA_WIDTH must be 8, 16 or 32.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_master #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  input  logic [2:0]              cmd_prot,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  // APB4 requester interface
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_q,     state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q,     pstrb_d;
  logic [2:0]              pprot_q,     pprot_d;

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             w_tmo_last;

  // The current ACCESS cycle is the TIMEOUT_CYCLES-th wait cycle: if pready
  // is still low here the counter reaches the limit on this edge and the
  // transfer is abandoned. A pready on this same cycle takes priority.
  assign w_tmo_last = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
`ifdef APB4_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        // cmd_ready is always high in IDLE, so cmd_valid alone is the
        // handshake. The APB output flops double as the command capture.
        if (cmd_valid) begin
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pprot_d     = cmd_prot;
          // Reads never present data or strobes on the bus.
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_wstrb : '0;
`ifdef APB4_MASTER_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        if (pready) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwdata_d    = '0;
          pstrb_d     = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end
`ifdef APB4_MASTER_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (w_tmo_last) begin
            state_d     = ST_RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            pwdata_d    = '0;
            pstrb_d     = '0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
`endif
      end

      ST_RESP: begin
        // Response fields stay frozen until the consumer takes them; the
        // command channel reopens on the cycle after the handshake.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. cmd_ready resets high so the block is ready
  // to accept as soon as reset is released; everything else resets to 0,
  // which drops psel/penable and discards any pending response at once.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
    end
  end

`ifdef APB4_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_master
// Purpose  : Directed self-checking bench for apb4_master. The bench plays
//            both the command source / response sink and the APB completer.
//            The timeout scenario runs only when APB4_MASTER_TIMEOUT_EN is
//            defined (TIMEOUT_CYCLES = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_vec = 0;
  int n_err = 0;

  apb4_master #(
    .ADDR_WIDTH     (3),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  // Step to 1 time unit after the next rising edge; outputs are sampled and
  // inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command while the DUT is idle; returns in the SETUP cycle.
  task automatic issue(input logic wr, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    cmd_wdata = d;    cmd_wstrb = s;  cmd_prot = p;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b1;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, pwdata, pstrb, pprot} !== '0) begin
      n_err++; $display("FAIL rst_outputs: got psel=%b pen=%b rv=%b re=%b rd=%h pa=%h pw=%b wd=%h st=%h pp=%h want all 0",
                        psel, penable, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, pwdata, pstrb, pprot);
    end
    n_vec++;
    rst = 1'b0;
    tick();
    if ({cmd_ready, psel, penable} !== 3'b100) begin
      n_err++; $display("FAIL rst_release: got cmd_ready/psel/penable=%b want 100", {cmd_ready, psel, penable});
    end
    n_vec++;
  endtask

  // Zero-wait write.
  task automatic test_write();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'hA5A5_5A5A; rsp_ready = 1'b1;
    issue(1'b1, 3'h4, 32'hDEAD_BEEF, 4'hF, 3'h2);
    // T+1 : SETUP
    if ({cmd_ready, psel, penable, pwrite, paddr, pprot} !== {1'b0, 1'b1, 1'b0, 1'b1, 3'h4, 3'h2}) begin
      n_err++; $display("FAIL wr_setup_ctl: got rdy/sel/en/wr/addr/prot=%b/%b/%b/%b/%h/%h want 0/1/0/1/4/2",
                        cmd_ready, psel, penable, pwrite, paddr, pprot);
    end
    n_vec++;
    if ({pwdata, pstrb} !== {32'hDEAD_BEEF, 4'hF}) begin
      n_err++; $display("FAIL wr_setup_data: got pwdata=%h pstrb=%h want deadbeef f", pwdata, pstrb);
    end
    n_vec++;
    tick();
    // T+2 : ACCESS
    if ({psel, penable, rsp_valid, pwdata, pstrb} !== {3'b110, 32'hDEAD_BEEF, 4'hF}) begin
      n_err++; $display("FAIL wr_access: got sel/en/rv=%b pwdata=%h pstrb=%h want 110 deadbeef f",
                        {psel, penable, rsp_valid}, pwdata, pstrb);
    end
    n_vec++;
    tick();
    // T+3 : RESP
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin
      n_err++; $display("FAIL wr_rsp: got rv=%b err=%b rdata=%h want 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    n_vec++;
    if ({psel, penable, pwdata, pstrb, paddr, pwrite} !== {2'b00, 32'h0, 4'h0, 3'h4, 1'b1}) begin
      n_err++; $display("FAIL wr_idle_bus: got sel/en=%b pwdata=%h pstrb=%h paddr=%h pwrite=%b want 00 0 0 4 1",
                        {psel, penable}, pwdata, pstrb, paddr, pwrite);
    end
    n_vec++;
    tick();
    // T+4 : back in IDLE
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL wr_back_idle: got rv/rdy=%b want 01", {rsp_valid, cmd_ready});
    end
    n_vec++;
  endtask

  // Read with three wait states; pslverr asserted while pready is low must be ignored.
  task automatic test_read_wait();
    pready = 1'b0; pslverr = 1'b1; prdata = 32'hFFFF_0000;
    issue(1'b0, 3'h2, 32'hFFFF_FFFF, 4'hF, 3'h0);
    for (int c = 1; c <= 5; c++) begin
      if ({psel, penable, rsp_valid, pwrite, paddr, pstrb, pwdata} !== {1'b1, (c >= 2), 1'b0, 1'b0, 3'h2, 4'h0, 32'h0}) begin
        n_err++; $display("FAIL rd_wait_c%0d: got sel/en/rv/wr=%b paddr=%h pstrb=%h pwdata=%h want 1%0b00 2 0 0",
                          c, {psel, penable, rsp_valid, pwrite}, paddr, pstrb, pwdata, (c >= 2));
      end
      n_vec++;
      if (c == 5) begin
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234_5678;
      end
      tick();
    end
    // T+6
    if ({rsp_valid, rsp_err, rsp_rdata, psel, penable} !== {2'b10, 32'h1234_5678, 2'b00}) begin
      n_err++; $display("FAIL rd_rsp: got rv=%b err=%b rdata=%h sel/en=%b want 1 0 12345678 00",
                        rsp_valid, rsp_err, rsp_rdata, {psel, penable});
    end
    n_vec++;
    pready = 1'b0; prdata = '0;
    tick();
  endtask

  // Completer error, then a clean follow-up write.
  task automatic test_slverr();
    pready = 1'b1; pslverr = 1'b1;
    issue(1'b1, 3'h1, 32'h0000_00FF, 4'h1, 3'h0);
    tick(); tick();
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL err_rsp: got rv=%b err=%b rdata=%h want 1 1 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    n_vec++;
    pslverr = 1'b0;
    tick();
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL err_next_ready: got cmd_ready=%b want 1", cmd_ready);
    end
    n_vec++;
    issue(1'b1, 3'h1, 32'h0000_0011, 4'h1, 3'h0);
    tick(); tick();
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      n_err++; $display("FAIL err_clean_rsp: got rv/err=%b want 10", {rsp_valid, rsp_err});
    end
    n_vec++;
    tick();
  endtask

  // Response back-pressure for 10 cycles while a new command is offered.
  task automatic test_rsp_stall();
    rsp_ready = 1'b0; pready = 1'b1; prdata = 32'hCAFE_F00D;
    issue(1'b0, 3'h5, 32'h0, 4'h0, 3'h7);
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
        n_err++; $display("FAIL stall_rsp_c%0d: got rv=%b err=%b rdata=%h want 1 0 cafef00d", c, rsp_valid, rsp_err, rsp_rdata);
      end
      n_vec++;
      if ({cmd_ready, psel, penable} !== 3'b000) begin
        n_err++; $display("FAIL stall_bus_c%0d: got rdy/sel/en=%b want 000", c, {cmd_ready, psel, penable});
      end
      n_vec++;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'h6;
      prdata = 32'(c);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    if ({rsp_valid, cmd_ready, psel, paddr} !== {3'b010, 3'h5}) begin
      n_err++; $display("FAIL stall_release: got rv/rdy/sel=%b paddr=%h want 010 5", {rsp_valid, cmd_ready, psel}, paddr);
    end
    n_vec++;
  endtask

  // Asynchronous reset during a stalled ACCESS, then a fresh read.
  task automatic test_reset_mid();
    rsp_ready = 1'b1; pready = 1'b0;
    issue(1'b1, 3'h6, 32'h1111_2222, 4'h3, 3'h0);
    tick();
    if ({psel, penable} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_access: got sel/en=%b want 11", {psel, penable});
    end
    n_vec++;
    #2 rst = 1'b1;
    #1;
    if ({psel, penable, rsp_valid, paddr, cmd_ready} !== {3'b000, 3'h0, 1'b1}) begin
      n_err++; $display("FAIL rstmid_async: got sel/en/rv=%b paddr=%h rdy=%b want 000 0 1",
                        {psel, penable, rsp_valid}, paddr, cmd_ready);
    end
    n_vec++;
    tick();
    rst = 1'b0;
    tick();
    if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
      n_err++; $display("FAIL rstmid_release: got rdy/sel/rv=%b want 100", {cmd_ready, psel, rsp_valid});
    end
    n_vec++;
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    issue(1'b0, 3'h3, 32'h0, 4'h0, 3'h0);
    tick(); tick();
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      n_err++; $display("FAIL rstmid_read: got rv=%b err=%b rdata=%h want 1 0 0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
    n_vec++;
    tick();
  endtask

`ifdef APB4_MASTER_TIMEOUT_EN
  // TIMEOUT_CYCLES = 8: pready never arrives, then arrives on the 8th ACCESS cycle.
  task automatic test_timeout();
    for (int v = 0; v < 2; v++) begin
      pready = 1'b0; prdata = 32'h7777_7777;
      issue(1'b0, 3'h7, 32'h0, 4'h0, 3'h0);
      tick();
      for (int c = 1; c <= 8; c++) begin
        if ({psel, penable, rsp_valid} !== 3'b110) begin
          n_err++; $display("FAIL tmo_v%0d_access_c%0d: got sel/en/rv=%b want 110", v, c, {psel, penable, rsp_valid});
        end
        n_vec++;
        if (v == 1 && c == 8) pready = 1'b1;
        tick();
      end
      if ({rsp_valid, rsp_err, rsp_rdata, psel, penable} !== {1'b1, (v == 0), ((v == 0) ? 32'h0 : 32'h7777_7777), 2'b00}) begin
        n_err++; $display("FAIL tmo_v%0d_rsp: got rv=%b err=%b rdata=%h sel/en=%b want 1 %0b %h 00", v,
                          rsp_valid, rsp_err, rsp_rdata, {psel, penable}, (v == 0), ((v == 0) ? 32'h0 : 32'h7777_7777));
      end
      n_vec++;
      pready = 1'b0;
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_rsp_stall();
    test_reset_mid();
`ifdef APB4_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/apb4_master.md
Name: apb4_master

Overview:
APB4 requester (completer-side counterpart of the existing APB4 slave/CSR path). Converts a simple valid/ready command stream into APB4 SETUP/ACCESS transfers and returns a valid/ready response. Used by firmware-less sequencers and the CSR test harness to drive apb4_slave-based register maps. Transfers are single-outstanding and non-pipelined.

Parameters:
ADDR_WIDTH, 3, APB address width (matches the CSR map).
DATA_WIDTH, 32, APB data width; must be 8, 16 or 32.
TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB4_MASTER_TIMEOUT_EN.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  PPROT value
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  PSLVERR or timeout
paddr  out  ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pprot  out  3  APB protection
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs registered.
- Reset, asynchronous: state IDLE; every output 0 except cmd_ready, which is 1 once rst deasserts.
- IDLE: cmd_ready=1. On cmd_valid, capture all cmd_* fields and go to SETUP. Command inputs are ignored in every other state.
- SETUP (1 cycle): psel=1, penable=0. paddr, pwrite, pprot, pwdata and pstrb are driven from the captured command.
- Reads drive pstrb=0 and pwdata=0.
- ACCESS: psel=1, penable=1, with all address, control and data signals held stable.
  - Stay while pready=0.
  - On pready=1, sample prdata (reads only; writes return 0) and pslverr into the response registers.
  - Same edge: psel=0, penable=0, go to RESP.
- pslverr is only meaningful with pready=1 and is ignored otherwise.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err stable until rsp_ready=1. On rsp_ready, go to IDLE.
- Latency: accept edge T gives SETUP in T+1 and ACCESS in T+2. With zero wait states, rsp_valid=1 in T+3.
  - Each pready-low cycle adds 1.
  - Minimum command-to-command spacing is 4 cycles.
- Back-to-back: cmd_ready reasserts the cycle after the rsp handshake. No overlap of APB phases.
- Reset mid-transfer: psel and penable drop to 0 immediately. The pending response is discarded and rsp_valid=0.
- Idle APB bus: psel=0, penable=0, paddr, pwrite and pprot hold their last values, pwdata=0 and pstrb=0.

Optional Feature:
APB4_MASTER_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP entry and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer ends: psel and penable go to 0 next edge, and RESP returns rsp_err=1, rsp_rdata=0.
  - A pready arriving on the timeout cycle wins and completes normally.
- Undefined: no counter logic; ACCESS waits indefinitely.

Test Plan:
1. Write addr=3'h4, data=32'hDEADBEEF, wstrb=4'hF, pready tied 1 -> psel high in T+1, penable in T+2, pwdata=DEADBEEF, pstrb=F; rsp_valid in T+3 with rsp_err=0, rsp_rdata=0.
2. Read addr=3'h2, slave returns 32'h12345678 after 3 wait states -> paddr stable for 5 cycles of psel; rsp_rdata=12345678 in T+6; pstrb=0 throughout.
3. Write with pslverr=1 on the pready cycle -> rsp_err=1; the next command is accepted normally with rsp_err=0.
4. rsp_ready held 0 for 10 cycles after a read -> rsp_valid, rsp_rdata and rsp_err stable; cmd_ready=0; no psel activity until rsp_ready=1.
5. rst asserted during ACCESS with pready=0 -> psel and penable go low without waiting for a clock edge, rsp_valid=0; after release cmd_ready=1 and a new read completes correctly.
6. (APB4_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8) pready held 0 -> transfer ends after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0. Repeat with pready=1 on the 8th cycle -> normal completion, rsp_err=0.
